// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch sequencer
//
// Purpose: FSM state encoding, BCD digit limit and default timing constants
// used by stopwatch_ctrl and button_debounce. No ports.

package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  localparam logic [3:0]  BCD_MAX             = 4'd9;
  localparam logic [23:0] TICK_COUNT_DEF      = 24'd10_000_000;
  localparam logic [15:0] DEBOUNCE_CYCLES_DEF = 16'd50_000;

endpackage

// File: rtl/stopwatch_if.sv
// rtl/stopwatch_if.sv - button and display bundle of the stopwatch sequencer
//
// Purpose: groups the raw push-button inputs and the display/status outputs.
// Signals:
//   btn_start_stop, btn_clear, btn_lap : raw asynchronous buttons, active-high
//   disp_ones, disp_tens               : displayed BCD digits
//   running, overflow, lap_active      : status flags
// Modports:
//   master : board side, drives the buttons and observes the display
//   slave  : stopwatch_ctrl side

interface stopwatch_if;

  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [3:0] disp_ones;
  logic [3:0] disp_tens;
  logic       running;
  logic       overflow;
  logic       lap_active;

  modport master (
    output btn_start_stop, btn_clear, btn_lap,
    input  disp_ones, disp_tens, running, overflow, lap_active
  );

  modport slave (
    input  btn_start_stop, btn_clear, btn_lap,
    output disp_ones, disp_tens, running, overflow, lap_active
  );

endinterface

// File: rtl/stopwatch_button_debounce.sv
// rtl/stopwatch_button_debounce.sv - button synchronizer, debouncer and press detector
//
// Purpose: 2-flop synchronizer, then a level debouncer that accepts a change
// only after DEBOUNCE_CYCLES consecutive cycles of disagreement, then a
// registered one-cycle pulse on the debounced rising edge.
// Raw edge to press pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   raw   : asynchronous button level
//   press : one-cycle pulse per accepted press

module button_debounce
  import stopwatch_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        level_dly_q;
  logic        press_q, press_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = 16'd0;
    // Counter only runs while the synchronized input disagrees; any agreement
    // clears it, so a glitch must persist the whole window to be accepted.
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch start/pause/clear sequencer with BCD seconds counter
//
// Purpose: debounces the buttons, runs the IDLE/RUN/PAUSE FSM, owns the tick
// prescaler and the 00..99 BCD seconds counter, and registers the display.
// Optional feature macro: STOPWATCH_LAP_EN (lap snapshot on btn_lap).
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   sw    : stopwatch_if.slave (buttons in; disp_ones, disp_tens, running,
//           overflow, lap_active out)

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter logic [23:0] TICK_COUNT      = TICK_COUNT_DEF,
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  stopwatch_if.slave  sw
);

  sw_state_e   state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic        ovf_q, ovf_d;
  logic        running_q, running_d;
  logic [3:0]  disp_ones_q, disp_ones_d;
  logic [3:0]  disp_tens_q, disp_tens_d;
  logic        tick;
  logic        ss_press, clr_press;
  logic        do_clear;

  // Lap view of the display: value of the lap flag and snapshot after this edge.
  logic        lap_cur;
  logic        lap_next;
  logic [3:0]  snap_ones_next, snap_tens_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clk   (clk),
    .reset (reset),
    .raw   (sw.btn_start_stop),
    .press (ss_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .reset (reset),
    .raw   (sw.btn_clear),
    .press (clr_press)
  );

  // Clear only acts from PAUSE; it also beats a simultaneous start_stop.
  assign do_clear = (state_q == PAUSE) && clr_press;

`ifdef STOPWATCH_LAP_EN
  logic       lap_press;
  logic       lap_q, lap_d;
  logic [3:0] snap_ones_q, snap_ones_d;
  logic [3:0] snap_tens_q, snap_tens_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk   (clk),
    .reset (reset),
    .raw   (sw.btn_lap),
    .press (lap_press)
  );

  always_comb begin
    lap_d       = lap_q;
    snap_ones_d = snap_ones_q;
    snap_tens_d = snap_tens_q;
    if ((state_q == RUN) && lap_press) begin
      lap_d = ~lap_q;
      // Snapshot the count as it stands before any tick on this edge.
      if (!lap_q) begin
        snap_ones_d = ones_q;
        snap_tens_d = tens_q;
      end
    end
    if (do_clear) begin
      lap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q       <= 1'b0;
      snap_ones_q <= 4'd0;
      snap_tens_q <= 4'd0;
    end else begin
      lap_q       <= lap_d;
      snap_ones_q <= snap_ones_d;
      snap_tens_q <= snap_tens_d;
    end
  end

  assign lap_cur        = lap_q;
  assign lap_next       = lap_d;
  assign snap_ones_next = snap_ones_d;
  assign snap_tens_next = snap_tens_d;
`else
  logic unused_btn_lap;
  assign unused_btn_lap = sw.btn_lap;
  assign lap_cur        = 1'b0;
  assign lap_next       = 1'b0;
  assign snap_ones_next = 4'd0;
  assign snap_tens_next = 4'd0;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    ovf_d   = ovf_q;
    tick    = 1'b0;

    // Prescaler advances only in RUN and is otherwise held, so a resume
    // completes the partial second.
    if (state_q == RUN) begin
      if (presc_q == TICK_COUNT - 24'd1) begin
        tick    = 1'b1;
        presc_d = 24'd0;
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end

    if (tick) begin
      if (ones_q == BCD_MAX) begin
        ones_d = 4'd0;
        if (tens_q == BCD_MAX) begin
          tens_d = 4'd0;
          ovf_d  = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (ss_press) state_d = RUN;
      end
      RUN: begin
        // A tick on the same edge has already been applied above.
        if (ss_press) state_d = PAUSE;
      end
      PAUSE: begin
        if (do_clear) begin
          state_d = IDLE;
          presc_d = 24'd0;
          ones_d  = 4'd0;
          tens_d  = 4'd0;
          ovf_d   = 1'b0;
        end else if (ss_press) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    running_d   = (state_d == RUN);
    disp_ones_d = lap_next ? snap_ones_next : ones_d;
    disp_tens_d = lap_next ? snap_tens_next : tens_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= 24'd0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      ovf_q       <= 1'b0;
      running_q   <= 1'b0;
      disp_ones_q <= 4'd0;
      disp_tens_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      ovf_q       <= ovf_d;
      running_q   <= running_d;
      disp_ones_q <= disp_ones_d;
      disp_tens_q <= disp_tens_d;
    end
  end

  assign sw.disp_ones  = disp_ones_q;
  assign sw.disp_tens  = disp_tens_q;
  assign sw.running    = running_q;
  assign sw.overflow   = ovf_q;
  assign sw.lap_active = lap_cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
//
// Purpose: drives button presses with TICK_COUNT=10, DEBOUNCE_CYCLES=4 and
// compares display/status outputs against a queue of expected values.
// A press driven on a falling edge changes the FSM on the 8th following
// rising edge (2 sync + 4 debounce + 1 pulse + 1 state register).

module tb_stopwatch_ctrl;

  localparam logic [23:0] TC = 24'd10;
  localparam logic [15:0] DC = 16'd4;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [10:0] v;   // {tens, ones, running, overflow, lap_active}
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  stopwatch_if sw ();

  stopwatch_ctrl #(.TICK_COUNT(TC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  function automatic logic [10:0] obs();
    return {sw.disp_tens, sw.disp_ones, sw.running, sw.overflow, sw.lap_active};
  endfunction

  task automatic push(input string n, input logic [3:0] t, input logic [3:0] o,
                      input logic r, input logic ov, input logic l);
    exp_t e;
    e.name = n;
    e.v    = {t, o, r, ov, l};
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sw.btn_start_stop = 1'b0;
    sw.btn_clear = 1'b0;
    sw.btn_lap = 1'b0;
    cycles(2);
    reset = 1'b0;
  endtask

  // Returns on the falling edge just after the edge where the press acts.
  task automatic press(input logic ss, input logic clr, input logic lap);
    sw.btn_start_stop = ss;
    sw.btn_clear = clr;
    sw.btn_lap = lap;
    cycles(8);
    sw.btn_start_stop = 1'b0;
    sw.btn_clear = 1'b0;
    sw.btn_lap = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    push("reset_state", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
  endtask

  task automatic test_glitch();
    exp_t e;
    do_reset();
    sw.btn_start_stop = 1'b1;
    cycles(3);
    sw.btn_start_stop = 1'b0;
    push("glitch_rejected", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    cycles(10);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    sw.btn_start_stop = 1'b1;
    push("press_latency_7", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    push("press_latency_8", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    cycles(7);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(1);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(2);
    sw.btn_start_stop = 1'b0;
    // 22 cycles into RUN, still running: only one press was taken.
    push("single_press", 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    cycles(20);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
  endtask

  task automatic test_pause_resume();
    exp_t e;
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    cycles(246);
    sw.btn_start_stop = 1'b1;            // pause lands at run cycle 254
    push("run_250", 4'd2, 4'd5, 1'b1, 1'b0, 1'b0);
    push("paused", 4'd2, 4'd5, 1'b0, 1'b0, 1'b0);
    push("pause_hold", 4'd2, 4'd5, 1'b0, 1'b0, 1'b0);
    cycles(4);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(4);
    sw.btn_start_stop = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(100);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    press(1'b1, 1'b0, 1'b0);
    push("resume_plus5", 4'd2, 4'd5, 1'b1, 1'b0, 1'b0);
    push("resume_plus6", 4'd2, 4'd6, 1'b1, 1'b0, 1'b0);
    cycles(5);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(1);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    // Pause press acting on the same edge as the next tick.
    cycles(2);
    push("tick_and_pause", 4'd2, 4'd7, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
  endtask

  task automatic test_overflow_clear();
    exp_t e;
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    push("count_99", 4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    push("wrap_00", 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    cycles(990);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(10);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    push("clear_in_run", 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    push("after_wrap_01", 4'd0, 4'd1, 1'b1, 1'b1, 1'b0);
    cycles(2);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    push("pause_keeps_ovf", 4'd0, 4'd1, 1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    push("clear_in_pause", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    // Cleared prescaler: first increment a full second after the restart.
    press(1'b1, 1'b0, 1'b0);
    push("restart_plus9", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    push("restart_plus10", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    cycles(9);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(1);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    cycles(30);
    push("pause_at_03", 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(6);
    push("clear_wins", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(6);
    push("idle_start", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    push("idle_start_tick", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(10);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    push("run_37", 4'd3, 4'd7, 1'b1, 1'b0, 1'b0);
    cycles(370);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    reset = 1'b1;
    sw.btn_start_stop = 1'b1;
    push("mid_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    cycles(1);
    reset = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    push("post_reset_7", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    push("post_reset_8", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    cycles(7);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    cycles(1);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    sw.btn_start_stop = 1'b0;
  endtask

  task automatic test_lap();
    exp_t e;
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    cycles(114);
    push("lap_set_12", 4'd1, 4'd2, 1'b1, 1'b0, LAP_EN);
    press(1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    push("lap_hold_at_20", 4'd1 + {3'd0, !LAP_EN}, LAP_EN ? 4'd2 : 4'd0, 1'b1, 1'b0, LAP_EN);
    cycles(78);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    push("lap_release", 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    press(1'b1, 1'b0, 1'b0);          // pause at run cycle 216
    push("lap_in_pause", 4'd2, 4'd1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    sw.btn_start_stop = 1'b0;
    sw.btn_clear = 1'b0;
    sw.btn_lap = 1'b0;
    test_reset();
    test_glitch();
    test_pause_resume();
    test_overflow_clear();
    test_simultaneous();
    test_reset_mid_run();
    test_lap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
